jtbubl_gfx_rom_slot: RTL
========================

# jtbubl_gfx_rom_slot

SDRAM-side responder for the graphics fetch interface. It serves the 19-bit word requests issued on `gfx_cs`/`gfx_addr` and answers with `gfx_data`/`gfx_ok`. It translates each miss into one handshaked burst-less read on the SDRAM controller port and holds the last returned word in a one-entry tagged buffer. It sits between the graphics block and the SDRAM arbiter in the game top level.

## Interface
Parameters:
- `OFFSET`, 22'h0 — SDRAM word base of the graphics region; added to `gfx_addr`.

Ports:
- `clk`  in  1  — system clock; the only clock.
- `rst_n`  in  1  — reset, synchronous, active-low.
- `gfx_cs`  in  1  — fetch request from the graphics block.
- `gfx_addr`  in  19  — word address within the graphics region.
- `gfx_data`  out  16  — returned word.
- `gfx_ok`  out  1  — `gfx_data` is valid for the current `gfx_addr`.
- `sdram_req`  out  1  — read request to the SDRAM controller.
- `sdram_addr`  out  22  — `OFFSET + gfx_addr`, latched at request.
- `sdram_ack`  in  1  — controller accepted the request.
- `data_rdy`  in  1  — controller read data strobe.
- `data_dst`  in  1  — the strobe belongs to this slot.
- `sdram_din`  in  16  — controller read data.

## Operation
- Tag buffer: `tag` (19 bits), `valid` (1 bit), `dbuf` (16 bits).
- `gfx_ok = gfx_cs & valid & (tag == gfx_addr) & (state == IDLE)`. This is combinational, so an address change drops `ok` in the same cycle.
- `gfx_data` is always `dbuf` (registered).
- FSM states:
  - **IDLE**:
    - On `gfx_cs` with a miss (`!valid` or `tag != gfx_addr`), latch `req_tag <= gfx_addr` and `sdram_addr <= OFFSET + gfx_addr`.
    - Set `sdram_req <= 1` and go to REQ.
    - A hit, or `gfx_cs` low, stays in IDLE.
  - **REQ**: hold `sdram_req` and `sdram_addr` stable until `sdram_ack`. Then clear `sdram_req` next edge and go to WAIT.
  - **WAIT**: on `data_rdy & data_dst`, load `dbuf <= sdram_din`, `tag <= req_tag`, `valid <= 1`, then go to IDLE.
- Address arithmetic: 22-bit unsigned; `gfx_addr` is zero-extended; the carry out of bit 21 is discarded (wraps).
- An SDRAM transaction is never aborted:
  - A `gfx_addr` change or `gfx_cs` drop in REQ/WAIT does not cancel it. The word is cached under `req_tag`.
  - On return to IDLE, the new address misses and triggers a fresh request.
- `data_rdy` without `data_dst`, or any strobe outside WAIT, is ignored.
- `sdram_ack` outside REQ is ignored.

## Timing
- Reset values: `sdram_req=0`, `sdram_addr=0`, `gfx_data=0`, `gfx_ok=0`, `valid=0`, `tag=0`, state=IDLE.
- Reset mid-transaction: the FSM goes to IDLE and `valid` clears. A late strobe from the aborted access is ignored because the FSM is not in WAIT.
- Miss seen at edge N → `sdram_req` high after edge N.
- `sdram_ack` seen at edge A → `sdram_req` low after edge A.
- Strobe seen at edge D → `dbuf`/`valid` updated and state=IDLE after D. `gfx_ok` rises in cycle D+1 if `gfx_addr` still equals `req_tag`.
- Minimum miss latency: 3 cycles plus controller latency. Hit latency: 0 cycles (combinational `ok`).
- Back-to-back misses: one idle cycle between consecutive `sdram_req` pulses (IDLE decision cycle).

## Structure
- Single flat module, roughly 130–180 lines.
- Shared package: FSM state encoding (IDLE=0, REQ=1, WAIT=2) and the address widths (19 for graphics, 22 for SDRAM) for reuse by other ROM slots.
- No sub-module. The tag compare is inline. A future multi-entry variant would factor out `jtbubl_slot_tagbuf`.

## Test plan
- **Reset then hold:** assert `rst_n=0` for 2 cycles, then release with `gfx_cs=0` → all outputs 0 and no `sdram_req` for 20 cycles.
- **Single miss:** `OFFSET=22'h10000`, `gfx_addr=19'h00123`, `cs=1`. Controller acks 2 cycles after req and returns `16'hBEEF` 4 cycles later → `sdram_addr=22'h10123`, `gfx_data=16'hBEEF`, and `ok` high exactly 1 cycle after the strobe.
- **Hit:** same address held after the miss, with `sdram_ack`/`data_rdy` tied low → `ok` stays high and no new `sdram_req` for 50 cycles.
- **Address change mid-flight:** switch `gfx_addr` to `19'h00124` while in WAIT → `ok` stays low. The first word is cached as tag `0x123`, a second request for `0x10124` issues, and `ok` rises only after its data returns.
- **Foreign strobe:** `data_rdy=1, data_dst=0` during WAIT → no update. A later `data_dst=1` completes normally.
- **Reset mid-transaction:** reset while in REQ, then deliver a strobe after release → `valid=0`, `ok=0`, `dbuf` unchanged.
- **Wrap:** `OFFSET=22'h3FFFFF`, `gfx_addr=19'h1` → `sdram_addr=22'h000000`.

Source files
------------

// File: rtl/jtbubl_gfx_rom_slot_pkg.sv
// Shared definitions for the jtbubl SDRAM ROM slots.
// Holds the slot FSM encoding and the address/data widths so that other
// ROM slots of the game top level can reuse them.
package jtbubl_gfx_rom_slot_pkg;

    localparam int unsigned GfxAw   = 19;  // graphics word address width
    localparam int unsigned SdramAw = 22;  // SDRAM word address width
    localparam int unsigned DataW   = 16;  // ROM word width

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } slot_state_e;

    // Zero-extend a graphics address and add the region base; carry out wraps.
    function automatic logic [SdramAw-1:0] gfx_to_sdram(
        input logic [SdramAw-1:0] base,
        input logic [GfxAw-1:0]   addr
    );
        return base + {{(SdramAw - GfxAw){1'b0}}, addr};
    endfunction

endpackage

// File: rtl/jtbubl_gfx_rom_slot.sv
// Graphics ROM slot: answers 19-bit word fetches from the graphics block out
// of a one-entry tagged buffer and turns every miss into a single read on the
// SDRAM controller port.
//
// Ports:
//   clk, rst_n              - system clock, synchronous active-low reset
//   gfx_cs, gfx_addr        - fetch request and word address
//   gfx_data, gfx_ok        - buffered word, valid for the current address
//   sdram_req, sdram_addr   - read request and latched SDRAM word address
//   sdram_ack               - controller accepted the request
//   data_rdy, data_dst      - read data strobe and "strobe is ours" qualifier
//   sdram_din               - controller read data
module jtbubl_gfx_rom_slot
    import jtbubl_gfx_rom_slot_pkg::*;
#(
    parameter logic [SdramAw-1:0] OFFSET = 22'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               gfx_cs,
    input  logic [GfxAw-1:0]   gfx_addr,
    output logic [DataW-1:0]   gfx_data,
    output logic               gfx_ok,
    output logic               sdram_req,
    output logic [SdramAw-1:0] sdram_addr,
    input  logic               sdram_ack,
    input  logic               data_rdy,
    input  logic               data_dst,
    input  logic [DataW-1:0]   sdram_din
);

    slot_state_e        state_q, state_d;
    logic [GfxAw-1:0]   tag_q, tag_d;
    logic [GfxAw-1:0]   req_tag_q, req_tag_d;
    logic               valid_q, valid_d;
    logic [DataW-1:0]   dbuf_q, dbuf_d;
    logic               req_q, req_d;
    logic [SdramAw-1:0] addr_q, addr_d;
    logic               hit;

    assign hit        = valid_q && (tag_q == gfx_addr);
    // Only trust the buffer in IDLE: in REQ/WAIT a refill may be in flight.
    assign gfx_ok     = gfx_cs && hit && (state_q == StIdle);
    assign gfx_data   = dbuf_q;
    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;

    always_comb begin
        state_d   = state_q;
        tag_d     = tag_q;
        req_tag_d = req_tag_q;
        valid_d   = valid_q;
        dbuf_d    = dbuf_q;
        req_d     = req_q;
        addr_d    = addr_q;
        unique case (state_q)
            StIdle: begin
                if (gfx_cs && !hit) begin
                    req_tag_d = gfx_addr;
                    addr_d    = gfx_to_sdram(OFFSET, gfx_addr);
                    req_d     = 1'b1;
                    state_d   = StReq;
                end
            end
            StReq: begin
                if (sdram_ack) begin
                    req_d   = 1'b0;
                    state_d = StWait;
                end
            end
            StWait: begin
                // The word is cached under the requested tag even if the
                // graphics side has moved on; a new address simply misses.
                if (data_rdy && data_dst) begin
                    dbuf_d  = sdram_din;
                    tag_d   = req_tag_q;
                    valid_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            tag_q     <= '0;
            req_tag_q <= '0;
            valid_q   <= 1'b0;
            dbuf_q    <= '0;
            req_q     <= 1'b0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            req_tag_q <= req_tag_d;
            valid_q   <= valid_d;
            dbuf_q    <= dbuf_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
        end
    end

endmodule
